// File: rtl/modulus_axis_if.sv
// AXI-Stream bundle shared by the sample input and magnitude output of modulus_axis.
// tsat is only meaningful on the magnitude side.
interface modulus_axis_if #(
  parameter int W = 32
);
  logic [W-1:0] tdata;
  logic         tsat;
  logic         tuser;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (
    output tdata,
    output tsat,
    output tuser,
    output tlast,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tuser,
    input  tlast,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/modulus_axis.sv
// Streaming complex-magnitude unit: three-stage pipeline (abs, sort, estimate/saturate)
// with four per-frame estimator modes and full valid/ready backpressure.
module modulus_axis #(
  parameter int DW     = 16,
  parameter int OW     = 16,
  parameter int ALPHA0 = 61,
  parameter int BETA0  = 26,
  parameter int ALPHA1 = 57,
  parameter int BETA1  = 31,
  parameter int CSHIFT = 6,
  parameter int PSHIFT = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           ce,
  input  logic [1:0]     mode,
  modulus_axis_if.slave  s_axis,
  modulus_axis_if.master m_axis
);

  localparam int EW = 2*DW + 8;
  localparam logic [EW-1:0] A0 = EW'(ALPHA0);
  localparam logic [EW-1:0] B0 = EW'(BETA0);
  localparam logic [EW-1:0] A1 = EW'(ALPHA1);
  localparam logic [EW-1:0] B1 = EW'(BETA1);

  logic          adv;
  logic          accept;
  logic [1:0]    mode_q;
  logic [1:0]    eff_mode;
  logic [DW-1:0] re_in;
  logic [DW-1:0] im_in;

  logic          s1_valid;
  logic [DW-1:0] s1_re;
  logic [DW-1:0] s1_im;
  logic          s1_user;
  logic          s1_last;
  logic [1:0]    s1_mode;

  logic          s2_valid;
  logic [DW-1:0] s2_max;
  logic [DW-1:0] s2_min;
  logic          s2_user;
  logic          s2_last;
  logic [1:0]    s2_mode;

  logic [EW-1:0] mx;
  logic [EW-1:0] mn;
  logic [EW-1:0] lin1;
  logic [EW-1:0] est;
  logic          sat;

  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_sat;
  logic          out_user;
  logic          out_last;

  // Negating the most negative value in DW-bit unsigned arithmetic yields 2^(DW-1), which is the exact magnitude.
  function automatic logic [DW-1:0] abs_val(input logic [DW-1:0] x);
    abs_val = x[DW-1] ? -x : x;
  endfunction

  assign adv           = ce && (!out_valid || m_axis.tready);
  assign s_axis.tready = adv;
  assign accept        = s_axis.tvalid && adv;
  assign re_in         = s_axis.tdata[DW-1:0];
  assign im_in         = s_axis.tdata[2*DW-1:DW];
  assign eff_mode      = (accept && s_axis.tuser) ? mode : mode_q;

  assign m_axis.tvalid = out_valid;
  assign m_axis.tdata  = out_data;
  assign m_axis.tsat   = out_sat;
  assign m_axis.tuser  = out_user;
  assign m_axis.tlast  = out_last;

  // Estimators run at full precision; truncation happens only in the final shift.
  always_comb begin
    mx   = {{(EW-DW){1'b0}}, s2_max};
    mn   = {{(EW-DW){1'b0}}, s2_min};
    lin1 = (mx*A1 + mn*B1) >> CSHIFT;
    case (s2_mode)
      2'd0:    est = (mx*A0 + mn*B0) >> CSHIFT;
      2'd1:    est = (lin1 > mx) ? lin1 : mx;
      2'd2:    est = (mx*mx + mn*mn) >> PSHIFT;
      default: est = mx + mn;
    endcase
    sat = |est[EW-1:OW];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= '0;
      s1_valid  <= 1'b0;
      s1_re     <= '0;
      s1_im     <= '0;
      s1_user   <= 1'b0;
      s1_last   <= 1'b0;
      s1_mode   <= '0;
      s2_valid  <= 1'b0;
      s2_max    <= '0;
      s2_min    <= '0;
      s2_user   <= 1'b0;
      s2_last   <= 1'b0;
      s2_mode   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
    end else if (adv) begin
      if (accept && s_axis.tuser) begin
        mode_q <= mode;
      end
      s1_valid <= accept;
      s1_re    <= abs_val(re_in);
      s1_im    <= abs_val(im_in);
      s1_user  <= s_axis.tuser;
      s1_last  <= s_axis.tlast;
      s1_mode  <= eff_mode;

      s2_valid <= s1_valid;
      s2_max   <= (s1_re >= s1_im) ? s1_re : s1_im;
      s2_min   <= (s1_re >= s1_im) ? s1_im : s1_re;
      s2_user  <= s1_user;
      s2_last  <= s1_last;
      s2_mode  <= s1_mode;

      out_valid <= s2_valid;
      out_data  <= sat ? {OW{1'b1}} : est[OW-1:0];
      out_sat   <= sat;
      out_user  <= s2_user;
      out_last  <= s2_last;
    end
  end

endmodule

// File: tb/tb_modulus_axis.sv
// Self-checking bench for modulus_axis: scoreboard of expected magnitudes plus a
// valid-bit model of the three-stage pipeline for handshake and latency checks.
module tb_modulus_axis;

  typedef struct {
    logic [15:0] data;
    logic        sat;
    logic        user;
    logic        last;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic       ce;
  logic [1:0] mode;

  modulus_axis_if #(.W(32)) s_if ();
  modulus_axis_if #(.W(16)) m_if ();

  assign s_if.tsat = 1'b0;

  modulus_axis dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ce      (ce),
    .mode    (mode),
    .s_axis  (s_if.slave),
    .m_axis  (m_if.master)
  );

  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];
  logic [2:0]  mv;
  logic [1:0]  mode_tb;
  bit          accepted;
  bit          fix_en;
  exp_t        fix_exp;
  int          cur_re;
  int          cur_im;
  int          pops;
  int          frame_pos;
  bit          bp_test;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference magnitude for DW=16, OW=16 and the default coefficients.
  function automatic exp_t model(input int re, input int im, input logic [1:0] md);
    longint ar, ai, mx, mn, v, l;
    exp_t e;
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    mx = (ar >= ai) ? ar : ai;
    mn = (ar >= ai) ? ai : ar;
    case (md)
      2'd0: v = (mx*61 + mn*26) >>> 6;
      2'd1: begin
        l = (mx*57 + mn*31) >>> 6;
        v = (l > mx) ? l : mx;
      end
      2'd2: v = (mx*mx + mn*mn) >>> 16;
      default: v = mx + mn;
    endcase
    e.sat  = (v > 65535);
    e.data = e.sat ? 16'hFFFF : v[15:0];
    e.user = 1'b0;
    e.last = 1'b0;
    return e;
  endfunction

  task automatic applyStimulus(input bit valid, input int re, input int im,
                               input bit user, input bit last, input logic [1:0] md);
    s_if.tvalid = valid;
    s_if.tdata  = {im[15:0], re[15:0]};
    s_if.tuser  = user;
    s_if.tlast  = last;
    mode        = md;
    cur_re      = re;
    cur_im      = im;
  endtask

  // Called just after a falling edge with inputs set; predicts the coming rising edge.
  task automatic stepCycle();
    logic madv;
    exp_t e;
    #1;
    madv = ce && (!mv[2] || m_if.tready);
    checkOutput("tready_s", s_if.tready, madv);
    checkOutput("tvalid_m", m_if.tvalid, mv[2]);
    if (mv[2] && madv) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        pops++;
        frame_pos = e.user ? 1 : frame_pos + 1;
        checkOutput("tdata_m", m_if.tdata, e.data);
        checkOutput("tsat_m",  m_if.tsat,  e.sat);
        checkOutput("tuser_m", m_if.tuser, e.user);
        checkOutput("tlast_m", m_if.tlast, e.last);
        if (bp_test && e.last) checkOutput("tlast_beat", frame_pos, 64);
      end
    end
    accepted = madv && s_if.tvalid;
    if (accepted) begin
      if (s_if.tuser) mode_tb = mode;
      e = fix_en ? fix_exp : model(cur_re, cur_im, mode_tb);
      e.user = s_if.tuser;
      e.last = s_if.tlast;
      sb.push_back(e);
    end
    if (madv) mv = {mv[1:0], accepted};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendBeat(input int re, input int im, input bit user, input bit last,
                          input logic [1:0] md, input bit fen, input int fdata, input bit fsat);
    bit done;
    fix_en       = fen;
    fix_exp.data = fdata[15:0];
    fix_exp.sat  = fsat;
    fix_exp.user = 1'b0;
    fix_exp.last = 1'b0;
    applyStimulus(1'b1, re, im, user, last, md);
    done = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      stepCycle();
      done = accepted;
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
    s_if.tvalid = 1'b0;
    fix_en      = 1'b0;
  endtask

  task automatic drain();
    m_if.tready = 1'b1;
    s_if.tvalid = 1'b0;
    for (int n = 0; n < 30 && (sb.size() != 0 || mv != 3'b000); n++) stepCycle();
    checkOutput("drain_left", sb.size(), 0);
  endtask

  initial begin
    int      bre[64];
    int      bim[64];
    logic [1:0] bmd[64];
    bit      stall_at[200];
    int      picked;
    int      b;
    int      c;

    reset_n = 1'b0;
    ce = 1'b1;
    mode = 2'd0;
    m_if.tready = 1'b1;
    mv = 3'b000;
    mode_tb = 2'd0;
    fix_en = 1'b0;
    pops = 0;
    frame_pos = 0;
    bp_test = 1'b0;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_tvalid_m", m_if.tvalid, 0);
    checkOutput("rst_tdata_m",  m_if.tdata,  0);
    checkOutput("rst_tsat_m",   m_if.tsat,   0);
    checkOutput("rst_tuser_m",  m_if.tuser,  0);
    checkOutput("rst_tlast_m",  m_if.tlast,  0);
    checkOutput("rst_tready_s", s_if.tready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] directed estimator values");
    sendBeat(3000, 4000, 1, 0, 2'd0, 1, 5031, 0);
    sendBeat(3000, 4000, 1, 0, 2'd1, 1, 5015, 0);
    sendBeat(3000, 4000, 1, 0, 2'd2, 1, 381, 0);
    sendBeat(3000, 4000, 1, 1, 2'd3, 1, 7000, 0);
    sendBeat(-32768, -32768, 1, 0, 2'd0, 1, 44544, 0);
    sendBeat(-32768, -32768, 1, 0, 2'd2, 1, 32768, 0);
    sendBeat(-32768, -32768, 1, 1, 2'd3, 1, 65535, 1);
    drain();

    $display("[TB] mode change only on frame start");
    sendBeat(3000, 4000, 1, 0, 2'd0, 1, 5031, 0);
    sendBeat(3000, 4000, 0, 0, 2'd2, 1, 5031, 0);
    sendBeat(3000, 4000, 1, 1, 2'd2, 1, 381, 0);
    drain();

    $display("[TB] clock enable freeze");
    sendBeat(1234, -567, 1, 0, 2'd1, 0, 0, 0);
    sendBeat(-20000, 300, 0, 0, 2'd1, 0, 0, 0);
    applyStimulus(1'b1, 777, 888, 1'b0, 1'b1, 2'd1);
    ce = 1'b0;
    repeat (3) stepCycle();
    ce = 1'b1;
    sendBeat(777, 888, 0, 1, 2'd1, 0, 0, 0);
    drain();

    $display("[TB] backpressure frame");
    for (int i = 0; i < 64; i++) begin
      bre[i] = int'($urandom_range(0, 65535)) - 32768;
      bim[i] = int'($urandom_range(0, 65535)) - 32768;
      bmd[i] = 2'($urandom_range(0, 3));
    end
    bre[10] = -32768;
    bim[10] = -32768;
    for (int i = 0; i < 200; i++) stall_at[i] = 1'b0;
    picked = 0;
    while (picked < 5) begin
      int k;
      k = int'($urandom_range(4, 60));
      if (!stall_at[k]) begin
        stall_at[k] = 1'b1;
        picked++;
      end
    end
    pops = 0;
    bp_test = 1'b1;
    b = 0;
    c = 0;
    while (b < 64 && c < 200) begin
      m_if.tready = !stall_at[c];
      applyStimulus(1'b1, bre[b], bim[b], b == 0, b == 63, bmd[b]);
      stepCycle();
      if (accepted) b++;
      c++;
    end
    if (b != 64) checkOutput("bp_accept_timeout", b, 64);
    drain();
    checkOutput("frame_beats", pops, 64);
    bp_test = 1'b0;

    $display("[TB] reset with beats in flight");
    sendBeat(100, 200, 1, 0, 2'd3, 0, 0, 0);
    sendBeat(300, 400, 0, 0, 2'd3, 0, 0, 0);
    sendBeat(500, 600, 0, 1, 2'd3, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_tvalid_m", m_if.tvalid, 0);
    checkOutput("mid_rst_tdata_m",  m_if.tdata,  0);
    checkOutput("mid_rst_tsat_m",   m_if.tsat,   0);
    checkOutput("mid_rst_tuser_m",  m_if.tuser,  0);
    checkOutput("mid_rst_tlast_m",  m_if.tlast,  0);
    sb.delete();
    mv = 3'b000;
    mode_tb = 2'd0;
    repeat (2) stepCycle();
    reset_n = 1'b1;
    sendBeat(3000, 4000, 0, 1, 2'd3, 1, 5031, 0);
    repeat (4) stepCycle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/modulus_axis.md
# modulus_axis

Parametrised streaming complex-magnitude unit, the successor to the fixed 16-bit alpha-max-beta-min stage. It sits between an FFT output and the spectrum/peak logic. Each AXI-Stream beat carries one complex sample {im, re}; the block emits one unsigned magnitude per beat. Differences from the fixed stage:
- Any data width.
- Four run-time estimator modes, latched per frame.
- Full valid/ready backpressure through the pipeline.
- Output saturation with a per-beat flag.

## Interface
- DW, 16: signed width of re and of im.
- OW, 16: unsigned output width.
- ALPHA0, 61; BETA0, 26: mode-0 coefficients, in units of 2^-CSHIFT.
- ALPHA1, 57; BETA1, 31: mode-1 second-region coefficients.
- CSHIFT, 6: coefficient fraction bits.
- PSHIFT, 16: right shift applied to the mode-2 power result.

- clk  in  1  clock; every register updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable; when low, all state holds and tready_s=0.
- mode  in  2  estimator select; sampled only on a frame-start beat.
- tdata_s  in  2*DW  [DW-1:0]=re, [2DW-1:DW]=im, both two's complement.
- tuser_s  in  1  frame start.
- tlast_s  in  1  frame end.
- tvalid_s  in  1  input valid.
- tready_s  out  1  input ready.
- tdata_m  out  OW  unsigned magnitude.
- tsat_m  out  1  set when the tdata_m beat was saturated.
- tuser_m, tlast_m  out  1 each  frame start/end, aligned with tdata_m.
- tvalid_m  out  1  output valid.
- tready_m  in  1  output ready.

## Operation
- Pipeline: three register stages, each with its own valid bit. tuser, tlast and the latched mode travel with the data.
  - S1: absolute values.
  - S2: sort into max/min.
  - S3: estimator, saturation, output registers.
- Advance enable: adv = ce && (!tvalid_m || tready_m). All stages shift together when adv=1; otherwise all hold.
- Input ready: tready_s = adv (combinational). A beat is accepted when tvalid_s && tready_s. When a beat is not accepted but adv=1, S1 loads a bubble (valid=0).
- S1 (absolute values):
  - |re| and |im| are computed as DW-bit unsigned. -2^(DW-1) maps exactly to 2^(DW-1); no wrap.
- Mode latch:
  - An accepted beat with tuser_s=1 loads mode_q from mode, and that beat uses the new value.
  - All other beats use mode_q.
  - mode_q resets to 0.
- S2 (sort): if |re| >= |im|, max=|re| and min=|im|; otherwise they swap.
- S3 estimators. Compute in full precision (2*DW+8 bits, unsigned); truncate by shifting only at the end:
  - mode 0: (max*ALPHA0 + min*BETA0) >> CSHIFT.
  - mode 1: larger of max and (max*ALPHA1 + min*BETA1) >> CSHIFT.
  - mode 2: (max^2 + min^2) >> PSHIFT.
  - mode 3: max + min (L1 norm).
- Saturation: if the result is >= 2^OW, tdata_m = 2^OW-1 and tsat_m=1; otherwise tsat_m=0.
- Flags: tuser/tlast pass through unchanged and stay aligned with their sample.
- Bubbles: bubbles never reach tvalid_m=1. tdata_m, tsat_m, tuser_m and tlast_m may update on bubbles, but are meaningful only while tvalid_m=1.

## Timing
- Reset values (asynchronous): tdata_m=0, tsat_m=0, tuser_m=0, tlast_m=0, tvalid_m=0, all stage valids=0, mode_q=0. tready_s then equals ce.
- Latency: a beat accepted on edge k appears on the outputs after edge k+2, i.e. three edges including acceptance. This holds when adv stays 1.
- Throughput: one beat per cycle while tready_m=1 and ce=1.
- Stall: while tvalid_m=1 && tready_m=0, all stages and outputs hold exactly, and tready_s=0 in the same cycle.
- Empty pipeline: tvalid_m=0 keeps adv=1 even when tready_m=0, so bubbles get squeezed out.
- ce low: full freeze with tready_s=0. Outputs hold, including tvalid_m; a downstream handshake may still complete on a held beat.
- Reset mid-stream: in-flight beats are discarded and no partial beat is emitted. The first beat after release takes the normal three-edge latency.
- Simultaneous tuser_s and tlast_s on the same beat (1-sample frame): legal; the mode is latched and both flags propagate.

## Test plan
- Mode 0, DW=16, re=3000, im=4000, tuser=1 → tdata_m=5031, tsat_m=0, tuser_m=1, three edges after acceptance.
- Same input in mode 1 → 5015; in mode 2 → 381; in mode 3 → 7000.
- re=im=-32768:
  - mode 0 → 44544, tsat_m=0.
  - mode 2 → 32768.
  - mode 3 → 65535 with tsat_m=1.
- Mode change mid-frame: mode toggles 0→2 on a non-tuser beat → output unchanged from mode 0. The next tuser beat switches results to mode 2.
- Backpressure: 64-beat frame of random samples, tready_m held low for 5 cycles at random points. Required:
  - tready_s=0 in exactly those cycles.
  - The output sequence matches a reference model with no loss or duplication.
  - tlast_m lands on beat 64.
- Reset asserted with 3 beats in flight → all outputs 0 immediately, no stale beat afterwards. The next accepted beat emerges three edges after acceptance.
